gba_mem_ctrl: RTL and testbench



---
 rtl/gba_mem_ctrl_if.sv | 31 +++
 rtl/gba_mem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gba_mem_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gba_mem_ctrl_if.sv
`timescale 1ns/1ps
// gba_mem_ctrl_if: core request bus plus req/ack backend port.
// The tri-state cpu_data lane stays a plain inout on the controller.
interface gba_mem_ctrl_if;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_width;
  logic        cpu_read;
  logic        cpu_write;
  logic        cpu_ok;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output cpu_addr, cpu_width, cpu_read, cpu_write,
    output bus_rdata, bus_ack,
    input  cpu_ok, bus_req, bus_we, bus_be,
    input  bus_addr, bus_wdata
  );

  modport slave (
    input  cpu_addr, cpu_width, cpu_read, cpu_write,
    input  bus_rdata, bus_ack,
    output cpu_ok, bus_req, bus_we, bus_be,
    output bus_addr, bus_wdata
  );
endinterface

// File: rtl/gba_mem_ctrl.sv
`timescale 1ns/1ps
// gba_mem_ctrl: GBA region decode, wait states, lane steering
// and backend timeout between the ARMv4T core and a req/ack port.
module gba_mem_ctrl #(
  parameter int WS_BIOS  = 0,
  parameter int WS_EWRAM = 2,
  parameter int WS_IWRAM = 0,
  parameter int WS_VRAM  = 0,
  parameter int WS_ROM   = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rstn,
  gba_mem_ctrl_if.slave io,
  inout  wire  [31:0]   cpu_data,
  output logic          timeout_err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    ws_q, ws_d;
  logic [TW-1:0] to_q, to_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    width_q, width_d;
  logic          we_q, we_d;
  logic          skip_q, skip_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [3:0]  rgn;
  logic        unmapped_n;
  logic        ro_n;
  logic        we_n;
  logic        skip_n;
  logic [7:0]  ws_n;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] rot;
  logic [31:0] rfmt;

  assign rgn  = io.cpu_addr[27:24];
  assign we_n = io.cpu_write & ~io.cpu_read;

  always_comb begin
    ws_n       = 8'd0;
    ro_n       = 1'b0;
    unmapped_n = io.cpu_addr[31:28] != 4'h0;
    case (rgn)
      4'h0: begin
        ws_n = 8'(WS_BIOS);
        ro_n = 1'b1;
      end
      4'h2: ws_n = 8'(WS_EWRAM);
      4'h3, 4'h4: ws_n = 8'(WS_IWRAM);
      4'h5, 4'h6, 4'h7: ws_n = 8'(WS_VRAM);
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
        ws_n = 8'(WS_ROM);
        ro_n = 1'b1;
      end
      default: unmapped_n = 1'b1;
    endcase
  end

  assign skip_n = unmapped_n | (we_n & ro_n);

  always_comb begin
    case (io.cpu_width)
      2'd0: begin
        be_n    = 4'b0001 << io.cpu_addr[1:0];
        wdata_n = {4{cpu_data[7:0]}};
      end
      2'd1: begin
        be_n    = io.cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{cpu_data[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = cpu_data;
      end
    endcase
  end

  // Word reads rotate like ARM misaligned LDR; bytes take the low lane.
  assign rot = 32'({rdata_q, rdata_q} >> {addr_q[1:0], 3'b000});

  always_comb begin
    case (width_q)
      2'd0:    rfmt = {24'h0, rot[7:0]};
      2'd1:    rfmt = {16'h0, addr_q[1] ? rdata_q[31:16] : rdata_q[15:0]};
      default: rfmt = rot;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    to_d    = to_q;
    addr_d  = addr_q;
    width_d = width_q;
    we_d    = we_q;
    skip_d  = skip_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (io.cpu_read | io.cpu_write) begin
          addr_d  = io.cpu_addr;
          width_d = io.cpu_width;
          we_d    = we_n;
          skip_d  = skip_n;
          be_d    = be_n;
          wdata_d = wdata_n;
          ws_d    = ws_n;
          to_d    = '0;
          state_d = (ws_n != 8'd0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        ws_d = ws_q - 8'd1;
        if (ws_q <= 8'd1) state_d = ACCESS;
      end
      ACCESS: begin
        if (skip_q) begin
          rdata_d = '0;
          state_d = DONE;
        end else if (io.bus_ack) begin
          rdata_d = io.bus_rdata;
          state_d = DONE;
        end else if (to_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      ws_q    <= '0;
      to_q    <= '0;
      addr_q  <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
      skip_q  <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      width_q <= width_d;
      we_q    <= we_d;
      skip_q  <= skip_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign io.cpu_ok    = state_q == DONE;
  assign io.bus_req   = (state_q == ACCESS) & ~skip_q;
  assign io.bus_we    = we_q;
  assign io.bus_be    = be_q;
  assign io.bus_addr  = {addr_q[31:2], 2'b00};
  assign io.bus_wdata = wdata_q;
  assign timeout_err  = err_q;

  assign cpu_data = (state_q == DONE && !we_q) ? rfmt : 32'hz;
endmodule

// File: tb/tb_gba_mem_ctrl.sv
`timescale 1ns/1ps
// tb_gba_mem_ctrl: directed bench for gba_mem_ctrl with a
// programmable ack-delay backend model.
module tb_gba_mem_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        timeout_err;
  logic        tb_drv;
  logic [31:0] tb_d;
  wire  [31:0] cpu_data;
  logic        ack_en;
  int          ack_dly;
  int          ack_cnt;
  logic [31:0] be_rdata;
  int          req_total = 0;
  int          ok_total = 0;
  int          checks = 0;
  int          errors = 0;

  gba_mem_ctrl_if io();

  assign cpu_data = tb_drv ? tb_d : 32'hz;

  gba_mem_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .io         (io),
    .cpu_data   (cpu_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!io.bus_req) begin
      ack_cnt = 0;
      io.bus_ack = 1'b0;
    end else if (ack_en && ack_cnt == ack_dly) begin
      io.bus_ack = 1'b1;
      ack_cnt++;
    end else begin
      io.bus_ack = 1'b0;
      ack_cnt++;
    end
    io.bus_rdata = be_rdata;
  end

  always @(posedge clk) begin
    if (io.bus_req) req_total++;
    if (io.cpu_ok) ok_total++;
  end

  task automatic issue(input bit rd, input bit wr,
                       input logic [31:0] a, input logic [1:0] w,
                       input logic [31:0] d);
    io.cpu_addr  = a;
    io.cpu_width = w;
    io.cpu_read  = rd;
    io.cpu_write = wr;
    tb_d   = d;
    tb_drv = wr && !rd;
  endtask

  task automatic wait_ok(input int maxc, output int lat,
                         output int rl, output logic [31:0] d,
                         output logic [3:0] be,
                         output logic [31:0] a,
                         output logic [31:0] wd, output logic we);
    lat = 0; rl = -1; d = 'x; be = 'x;
    a = 'x; wd = 'x; we = 1'bx;
    while (lat < maxc) begin
      @(negedge clk);
      lat++;
      if (io.bus_req && rl < 0) begin
        rl = lat; be = io.bus_be; a = io.bus_addr;
        wd = io.bus_wdata; we = io.bus_we;
      end
      if (io.cpu_ok) begin
        d = cpu_data;
        break;
      end
    end
    io.cpu_read = 1'b0;
    io.cpu_write = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (io.cpu_ok !== 1'b0 || io.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_ok_req: got %b%b want 00", io.cpu_ok, io.bus_req);
    end
    checks++;
    if (io.bus_be !== 4'h0 || io.bus_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_be_we: got %h/%b want 0/0", io.bus_be, io.bus_we);
    end
    checks++;
    if (io.bus_addr !== 32'h0 || io.bus_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_addr_wd: got %h/%h want 0/0", io.bus_addr, io.bus_wdata);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err: got %b want 0", timeout_err);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_iwram_read;
    int lat, rl, rb;
    logic [31:0] d, a, wd;
    logic [3:0] be;
    logic we;
    be_rdata = 32'hDEADBEEF; ack_en = 1'b1; ack_dly = 0;
    issue(1, 0, 32'h0300_0004, 2'd2, 32'h0);
    rb = req_total;
    wait_ok(20, lat, rl, d, be, a, wd, we);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL iw_lat: got %0d want 2", lat);
    end
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL iw_data: got %h want deadbeef", d);
    end
    checks++;
    if (be !== 4'b1111 || a !== 32'h0300_0004 || we !== 1'b0) begin
      errors++;
      $display("FAIL iw_bus: got be=%b a=%h we=%b want 1111 03000004 0", be, a, we);
    end
    @(negedge clk);
    checks++;
    if (req_total - rb !== 1) begin
      errors++; $display("FAIL iw_req: got %0d want 1", req_total - rb);
    end
  endtask

  task automatic test_ewram_byte_write;
    int lat, rl, ob;
    logic [31:0] d, a, wd;
    logic [3:0] be;
    logic we;
    ack_en = 1'b1; ack_dly = 0;
    issue(0, 1, 32'h0200_0003, 2'd0, 32'h1234_565A);
    ob = ok_total;
    wait_ok(20, lat, rl, d, be, a, wd, we);
    checks++;
    if (rl !== 3) begin
      errors++; $display("FAIL ew_access: got %0d want 3", rl);
    end
    checks++;
    if (be !== 4'b1000 || we !== 1'b1) begin
      errors++; $display("FAIL ew_be_we: got %b/%b want 1000/1", be, we);
    end
    checks++;
    if (wd !== 32'h5A5A_5A5A || a !== 32'h0200_0000) begin
      errors++;
      $display("FAIL ew_wd_addr: got %h/%h want 5a5a5a5a/02000000", wd, a);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL ew_lat: got %0d want 4", lat);
    end
    @(negedge clk);
    checks++;
    if (ok_total - ob !== 1 || io.cpu_ok !== 1'b0) begin
      errors++;
      $display("FAIL ew_okpulse: got %0d/%b want 1/0", ok_total - ob, io.cpu_ok);
    end
  endtask

  task automatic test_rom_misaligned;
    int lat, rl;
    logic [31:0] d, a, wd;
    logic [3:0] be;
    logic we;
    be_rdata = 32'h1122_3344; ack_en = 1'b1; ack_dly = 0;
    issue(1, 0, 32'h0800_0002, 2'd2, 32'h0);
    wait_ok(30, lat, rl, d, be, a, wd, we);
    checks++;
    if (d !== 32'h3344_1122 || lat !== 6) begin
      errors++;
      $display("FAIL rom_word: got %h lat %0d want 33441122 lat 6", d, lat);
    end
    checks++;
    if (a !== 32'h0800_0000 || be !== 4'b1111) begin
      errors++; $display("FAIL rom_word_bus: got %h/%b want 08000000/1111", a, be);
    end
    @(negedge clk);
    issue(1, 0, 32'h0800_0002, 2'd1, 32'h0);
    wait_ok(30, lat, rl, d, be, a, wd, we);
    checks++;
    if (d !== 32'h0000_1122 || be !== 4'b1100) begin
      errors++; $display("FAIL rom_half: got %h/%b want 00001122/1100", d, be);
    end
    @(negedge clk);
    ack_dly = 2;
    issue(1, 0, 32'h0800_0001, 2'd0, 32'h0);
    wait_ok(30, lat, rl, d, be, a, wd, we);
    checks++;
    if (d !== 32'h0000_0033 || be !== 4'b0010 || lat !== 8) begin
      errors++;
      $display("FAIL rom_byte: got %h/%b lat %0d want 00000033/0010 lat 8", d, be, lat);
    end
    ack_dly = 0;
    @(negedge clk);
  endtask

  task automatic test_skip;
    int lat, rl, rb;
    logic [31:0] d, a, wd;
    logic [3:0] be;
    logic we;
    be_rdata = 32'hFFFF_FFFF; ack_en = 1'b1;
    issue(0, 1, 32'h0000_0010, 2'd2, 32'hAAAA_5555);
    rb = req_total;
    wait_ok(20, lat, rl, d, be, a, wd, we);
    @(negedge clk);
    checks++;
    if (lat !== 2 || req_total - rb !== 0) begin
      errors++;
      $display("FAIL bios_wr: got lat %0d req %0d want lat 2 req 0", lat, req_total - rb);
    end
    issue(1, 0, 32'h0100_0000, 2'd2, 32'h0);
    rb = req_total;
    wait_ok(20, lat, rl, d, be, a, wd, we);
    @(negedge clk);
    checks++;
    if (lat !== 2 || d !== 32'h0 || req_total - rb !== 0) begin
      errors++;
      $display("FAIL unmap_rd: got lat %0d d %h req %0d want 2 0 0", lat, d, req_total - rb);
    end
    issue(1, 0, 32'h1300_0000, 2'd2, 32'h0);
    rb = req_total;
    wait_ok(20, lat, rl, d, be, a, wd, we);
    @(negedge clk);
    checks++;
    if (d !== 32'h0 || req_total - rb !== 0) begin
      errors++; $display("FAIL hi_unmap: got d %h req %0d want 0 0", d, req_total - rb);
    end
    issue(0, 1, 32'h0800_0000, 2'd2, 32'h1);
    rb = req_total;
    wait_ok(20, lat, rl, d, be, a, wd, we);
    @(negedge clk);
    checks++;
    if (lat !== 6 || req_total - rb !== 0) begin
      errors++;
      $display("FAIL rom_wr: got lat %0d req %0d want 6 0", lat, req_total - rb);
    end
  endtask

  task automatic test_timeout;
    int lat, rl, rb;
    logic [31:0] d, a, wd;
    logic [3:0] be;
    logic we;
    be_rdata = 32'h7777_7777; ack_en = 1'b0;
    issue(1, 0, 32'h0300_0000, 2'd2, 32'h0);
    rb = req_total;
    wait_ok(200, lat, rl, d, be, a, wd, we);
    checks++;
    if (lat !== 65 || d !== 32'h0) begin
      errors++; $display("FAIL to_ok: got lat %0d d %h want 65 0", lat, d);
    end
    @(negedge clk);
    checks++;
    if (req_total - rb !== 64) begin
      errors++; $display("FAIL to_req: got %0d want 64", req_total - rb);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_err: got %b want 1", timeout_err);
    end
    ack_en = 1'b1;
    issue(1, 0, 32'h0300_0000, 2'd2, 32'h0);
    wait_ok(20, lat, rl, d, be, a, wd, we);
    @(negedge clk);
    checks++;
    if (d !== 32'h7777_7777 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %h/%b want 77777777/1", d, timeout_err);
    end
  endtask

  task automatic test_reset_mid;
    int lat, rl;
    logic [31:0] d, a, wd;
    logic [3:0] be;
    logic we;
    be_rdata = 32'h0BAD_F00D; ack_en = 1'b0;
    issue(1, 0, 32'h0300_0008, 2'd2, 32'h0);
    @(negedge clk);
    checks++;
    if (io.bus_req !== 1'b1) begin
      errors++; $display("FAIL rm_pre: got %b want 1", io.bus_req);
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (io.bus_req !== 1'b0 || io.cpu_ok !== 1'b0) begin
      errors++;
      $display("FAIL rm_drop: got %b%b want 00", io.bus_req, io.cpu_ok);
    end
    rstn = 1'b1;
    ack_en = 1'b1;
    wait_ok(20, lat, rl, d, be, a, wd, we);
    checks++;
    if (lat !== 2 || d !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL rm_redo: got lat %0d d %h want 2 0badf00d", lat, d);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL rm_err: got %b want 0", timeout_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, rl;
    logic [31:0] d, a, wd;
    logic [3:0] be;
    logic we;
    be_rdata = 32'hCAFE_F00D; ack_en = 1'b1; ack_dly = 0;
    issue(1, 0, 32'h0300_0010, 2'd2, 32'h0);
    wait_ok(20, lat, rl, d, be, a, wd, we);
    checks++;
    if (d !== 32'hCAFE_F00D || lat !== 2) begin
      errors++; $display("FAIL b2b_first: got %h lat %0d want cafef00d 2", d, lat);
    end
    issue(1, 0, 32'h0300_0011, 2'd0, 32'h0);
    wait_ok(20, lat, rl, d, be, a, wd, we);
    checks++;
    if (d !== 32'h0000_00F0 || lat !== 3) begin
      errors++; $display("FAIL b2b_byte: got %h lat %0d want 000000f0 3", d, lat);
    end
    issue(1, 1, 32'h0300_0000, 2'd2, 32'h0);
    wait_ok(20, lat, rl, d, be, a, wd, we);
    checks++;
    if (we !== 1'b0 || d !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_rdprio: got we %b d %h want 0 cafef00d", we, d);
    end
    issue(0, 1, 32'h0300_0002, 2'd1, 32'hAAAA_BEEF);
    wait_ok(20, lat, rl, d, be, a, wd, we);
    checks++;
    if (be !== 4'b1100 || wd !== 32'hBEEF_BEEF || we !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL b2b_half: got %b %h %b lat %0d want 1100 beefbeef 1 3", be, wd, we, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    io.cpu_addr = '0;
    io.cpu_width = '0;
    io.cpu_read = 1'b0;
    io.cpu_write = 1'b0;
    tb_drv = 1'b0;
    tb_d = '0;
    ack_en = 1'b1;
    ack_dly = 0;
    be_rdata = '0;
    rstn = 1'b0;
    test_reset();
    test_iwram_read();
    test_ewram_byte_write();
    test_rom_misaligned();
    test_skip();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
